// File: rtl/exc_ctrl_unit.sv
// Exception controller: detects illegal opcode / overflow / irq, flushes the pipeline,
// vectors to a per-cause handler and tracks handler return and double faults.
module exc_ctrl_unit #(
    parameter int unsigned              INSTR_W      = 16,
    parameter int unsigned              OPC_W        = 4,
    parameter logic [(2**OPC_W)-1:0]    LEGAL_MASK   = 16'h9971,
    parameter int unsigned              PC_W         = 16,
    parameter logic [PC_W-1:0]          VEC_BASE     = 16'hFF00,
    parameter int unsigned              FLUSH_CYCLES = 2,
    parameter int unsigned              CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [INSTR_W-1:0] instruct,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               overflow,
    input  logic               irq,
    input  logic               eret,
    output logic               exc_flag,
    output logic               flush,
    output logic               redirect,
    output logic [PC_W-1:0]    vector_pc,
    output logic [PC_W-1:0]    epc,
    output logic [1:0]         cause,
    output logic               in_handler,
    output logic               double_fault,
    output logic [CNT_W-1:0]   exc_count
);

    localparam int unsigned     FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StVector,
        StHandler,
        StReturn,
        StHalt
    } state_e;

    state_e state_q, state_d;

    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             exc_flag_q, exc_flag_d;
    logic             flush_q, flush_d;
    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  vector_pc_q, vector_pc_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic             in_handler_q, in_handler_d;
    logic             double_fault_q, double_fault_d;
    logic [CNT_W-1:0] exc_count_q, exc_count_d;

    logic [OPC_W-1:0] opcode;
    logic             illegal;
    logic             ovf;
    logic             unused_instr;

    assign opcode       = instruct[INSTR_W-1 -: OPC_W];
    assign illegal      = valid_in & ~LEGAL_MASK[opcode];
    assign ovf          = valid_in & overflow & ~illegal;
    // Only the opcode field matters here; the remaining bits are intentionally ignored.
    assign unused_instr = ^instruct;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            fcnt_q         <= '0;
            exc_flag_q     <= 1'b0;
            flush_q        <= 1'b0;
            redirect_q     <= 1'b0;
            vector_pc_q    <= '0;
            epc_q          <= '0;
            cause_q        <= 2'b00;
            in_handler_q   <= 1'b0;
            double_fault_q <= 1'b0;
            exc_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            exc_flag_q     <= exc_flag_d;
            flush_q        <= flush_d;
            redirect_q     <= redirect_d;
            vector_pc_q    <= vector_pc_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            in_handler_q   <= in_handler_d;
            double_fault_q <= double_fault_d;
            exc_count_q    <= exc_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StIdle: begin
                if (illegal || ovf || irq) begin
                    state_d = StFlush;
                    fcnt_d  = FC_LOAD;
                end
            end
            StFlush: begin
                fcnt_d = fcnt_q - FC_W'(1);
                if (fcnt_q == FC_W'(1)) begin
                    state_d = StVector;
                end
            end
            StVector: state_d = StHandler;
            StHandler: begin
                // irq is masked here; a fault beats a simultaneous eret
                if (illegal || ovf) begin
                    state_d = StHalt;
                end else if (eret) begin
                    state_d = StReturn;
                end
            end
            StReturn: state_d = StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Output registers are loaded from the next state so they line up with it.
    always_comb begin
        exc_flag_d     = (state_q == StIdle) && (state_d == StFlush);
        flush_d        = (state_d == StFlush) || (state_d == StHalt);
        redirect_d     = (state_d == StVector) || (state_d == StReturn);
        in_handler_d   = (state_d == StHandler) || (state_d == StHalt);
        double_fault_d = double_fault_q || (state_d == StHalt);
        vector_pc_d    = vector_pc_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        exc_count_d    = exc_count_q;

        if (exc_flag_d) begin
            epc_d = pc_in;
            if (illegal) begin
                cause_d = 2'b01;
            end else if (ovf) begin
                cause_d = 2'b10;
            end else begin
                cause_d = 2'b11;
            end
            if (!(&exc_count_q)) begin
                exc_count_d = exc_count_q + CNT_W'(1);
            end
        end

        if (state_q == StFlush && state_d == StVector) begin
            vector_pc_d = VEC_BASE + PC_W'({cause_q, 2'b00});
        end

        // Interrupts re-execute the interrupted instruction; faults skip it.
        if (state_q == StHandler && state_d == StReturn) begin
            vector_pc_d = (cause_q == 2'b11) ? epc_q : epc_q + PC_W'(1);
        end

        if (state_q == StReturn) begin
            cause_d = 2'b00;
        end
    end

    assign exc_flag     = exc_flag_q;
    assign flush        = flush_q;
    assign redirect     = redirect_q;
    assign vector_pc    = vector_pc_q;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign in_handler   = in_handler_q;
    assign double_fault = double_fault_q;
    assign exc_count    = exc_count_q;

endmodule

// File: tb/tb_exc_ctrl_unit.sv
// Directed self-checking bench for exc_ctrl_unit with hand-computed expectations.
module tb_exc_ctrl_unit;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [15:0] instruct;
    logic [15:0] pc_in;
    logic        overflow;
    logic        irq;
    logic        eret;
    logic        exc_flag;
    logic        flush;
    logic        redirect;
    logic [15:0] vector_pc;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        in_handler;
    logic        double_fault;
    logic [7:0]  exc_count;

    int n_pass;
    int n_total;

    exc_ctrl_unit dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .instruct     (instruct),
        .pc_in        (pc_in),
        .overflow     (overflow),
        .irq          (irq),
        .eret         (eret),
        .exc_flag     (exc_flag),
        .flush        (flush),
        .redirect     (redirect),
        .vector_pc    (vector_pc),
        .epc          (epc),
        .cause        (cause),
        .in_handler   (in_handler),
        .double_fault (double_fault),
        .exc_count    (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {exc_flag, flush, redirect, in_handler, double_fault}
    function automatic logic [4:0] status();
        return {exc_flag, flush, redirect, in_handler, double_fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        instruct = 16'h0000;
        overflow = 1'b0;
        eret     = 1'b0;
    endtask

    // Unchecked overflow exception followed by eret; takes six cycles.
    task automatic ovf_seq();
        valid_in = 1'b1;
        instruct = 16'h0000;
        overflow = 1'b1;
        pc_in    = 16'h1000;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        irq     = 1'b0;
        pc_in   = 16'h0000;
        idle_inputs();
        tick();
        check_eq("reset_status", 32'(status()), 32'h00);
        check_eq("reset_count", 32'(exc_count), 32'h00);
        #3 reset = 1'b0;

        // Overflow at 0x0020, then asynchronous reset while flushing
        valid_in = 1'b1;
        overflow = 1'b1;
        pc_in    = 16'h0020;
        tick();
        idle_inputs();
        check_eq("pre_rst_status", 32'(status()), 32'b11000);
        check_eq("pre_rst_count", 32'(exc_count), 32'h01);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_status", 32'(status()), 32'h00);
        check_eq("async_rst_epc", 32'(epc), 32'h0000);
        check_eq("async_rst_cause", 32'(cause), 32'h0);
        check_eq("async_rst_count", 32'(exc_count), 32'h00);
        #2 reset = 1'b0;
        tick();
        check_eq("post_rst_idle", 32'(status()), 32'h00);

        // Illegal opcode 3 at 0x0040
        valid_in = 1'b1;
        instruct = 16'h3000;
        pc_in    = 16'h0040;
        tick();
        idle_inputs();
        check_eq("ill_status0", 32'(status()), 32'b11000);
        check_eq("ill_cause", 32'(cause), 32'h1);
        check_eq("ill_epc", 32'(epc), 32'h0040);
        check_eq("ill_count", 32'(exc_count), 32'h01);
        tick();
        check_eq("ill_status1", 32'(status()), 32'b01000);
        tick();
        check_eq("ill_vector", 32'(status()), 32'b00100);
        check_eq("ill_vpc", 32'(vector_pc), 32'hFF04);
        tick();
        check_eq("ill_handler", 32'(status()), 32'b00010);
        check_eq("ill_vpc_hold", 32'(vector_pc), 32'hFF04);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("ill_return", 32'(status()), 32'b00100);
        check_eq("ill_ret_vpc", 32'(vector_pc), 32'h0041);
        tick();
        check_eq("ill_idle", 32'(status()), 32'b00000);
        check_eq("ill_cause_clr", 32'(cause), 32'h0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("idle_eret_ignored", 32'(status()), 32'b00000);

        // Overflow at 0xFFFF: return address wraps to 0x0000
        valid_in = 1'b1;
        instruct = 16'h4123;
        overflow = 1'b1;
        pc_in    = 16'hFFFF;
        tick();
        idle_inputs();
        check_eq("ovf_cause", 32'(cause), 32'h2);
        check_eq("ovf_epc", 32'(epc), 32'hFFFF);
        tick();
        tick();
        check_eq("ovf_vpc", 32'(vector_pc), 32'hFF08);
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("ovf_ret_vpc", 32'(vector_pc), 32'h0000);
        tick();
        check_eq("ovf_count", 32'(exc_count), 32'h02);

        // irq together with illegal opcode: illegal wins, irq taken after return
        irq      = 1'b1;
        valid_in = 1'b1;
        instruct = 16'h3000;
        pc_in    = 16'h0010;
        tick();
        idle_inputs();
        pc_in = 16'h0123;
        check_eq("prio_cause", 32'(cause), 32'h1);
        check_eq("prio_epc", 32'(epc), 32'h0010);
        tick();
        tick();
        tick();
        tick();
        check_eq("irq_masked", 32'(status()), 32'b00010);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("prio_ret_vpc", 32'(vector_pc), 32'h0011);
        tick();
        check_eq("prio_idle", 32'(status()), 32'b00000);
        tick();
        check_eq("irq_status", 32'(status()), 32'b11000);
        check_eq("irq_cause", 32'(cause), 32'h3);
        check_eq("irq_epc", 32'(epc), 32'h0123);
        irq = 1'b0;
        tick();
        tick();
        check_eq("irq_vpc", 32'(vector_pc), 32'hFF0C);
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("irq_ret_vpc", 32'(vector_pc), 32'h0123);
        tick();
        check_eq("irq_count", 32'(exc_count), 32'h04);

        // Double fault: overflow plus eret inside the handler
        valid_in = 1'b1;
        overflow = 1'b1;
        pc_in    = 16'h0200;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        valid_in = 1'b1;
        overflow = 1'b1;
        eret     = 1'b1;
        pc_in    = 16'h0300;
        tick();
        idle_inputs();
        check_eq("df_status", 32'(status()), 32'b01011);
        check_eq("df_epc", 32'(epc), 32'h0200);
        check_eq("df_cause", 32'(cause), 32'h2);
        check_eq("df_count", 32'(exc_count), 32'h05);
        irq  = 1'b1;
        eret = 1'b1;
        tick();
        tick();
        tick();
        irq  = 1'b0;
        eret = 1'b0;
        check_eq("df_stuck", 32'(status()), 32'b01011);
        #2 reset = 1'b1;
        #1;
        check_eq("df_reset", 32'(status()), 32'h00);
        #2 reset = 1'b0;

        // Counter saturation
        for (int i = 0; i < 254; i++) begin
            ovf_seq();
        end
        check_eq("count_254", 32'(exc_count), 32'hFE);
        for (int i = 0; i < 46; i++) begin
            ovf_seq();
        end
        check_eq("count_sat", 32'(exc_count), 32'hFF);
        check_eq("sat_idle", 32'(status()), 32'b00000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
